c2f_req_buf: RTL
================

# c2f_req_buf

Core-to-fabric request buffer between the data-memory wrapper's non-local access port (Q500H) and the ring stop. It absorbs C2F read/write requests in an in-order FIFO and presents them to the ring under its stall back-pressure. It also tracks one pending-read flag per hardware thread, cleared by the matching Q502H response, and records sticky protocol errors for debug CRs.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- QClk  in  1  clock; all state updates on the rising edge.
- RstQnnnH  in  1  reset, synchronous, active-high.
- C2F_ReqValidQ500H  in  1  core request valid.
- C2F_ReqOpcodeQ500H  in  t_opcode  RD or WR.
- C2F_ReqThreadIDQ500H  in  2  issuing thread.
- C2F_ReqAddressQ500H  in  32  target address.
- C2F_ReqDataQ500H  in  32  write data (don't-care for RD).
- C2F_ReqFullQ500H  out  1  FIFO full; core must not issue.
- C2F_RingReqValidQ501H  out  1  head entry valid toward ring.
- C2F_RingReqOpcodeQ501H  out  t_opcode  head opcode.
- C2F_RingReqThreadIDQ501H  out  2  head thread.
- C2F_RingReqAddressQ501H  out  32  head address.
- C2F_RingReqDataQ501H  out  32  head data.
- C2F_RspStall  in  1  ring cannot accept head this cycle.
- C2F_RspValidQ502H  in  1  ring response valid.
- C2F_RspThreadIDQ502H  in  2  responding thread.
- ThreadRdPending  out  4  per-thread outstanding read, bit n = thread n.
- C2F_BufCount  out  $clog2(DEPTH)+1  occupied entries.
- C2F_ErrSticky  out  2  [0] overflow drop, [1] response with no pending read.

## Operation
- Push = C2F_ReqValidQ500H && !C2F_ReqFullQ500H. Stores {opcode, thread, address, data} at the write pointer.
- Pop = C2F_RingReqValidQ501H && !C2F_RspStall. Advances the read pointer.
- Full = (count == DEPTH), decoded from the registered count.
- Push attempted while full: request dropped, no state change except C2F_ErrSticky[0] <= 1. This holds even if a pop occurs the same cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count saturates by construction: no push at DEPTH, no pop at 0.
- Strict in-order issue. The ring-side outputs are the head entry, read combinationally from registered storage. When empty, valid = 0 and data outputs = 0.
- Pending tracking, per thread n:
  - set on a push of an RD with thread n;
  - clear on C2F_RspValidQ502H with thread n.
  - Set and clear for the same thread in the same cycle: result 1 (new read supersedes).
  - Response for thread n with pending[n] = 0: C2F_ErrSticky[1] <= 1, pending unchanged.
  - WR pushes never set pending. WR responses, if any, are treated as responses and follow the rule above.
- C2F_ErrSticky bits clear only on reset.

## Timing
- Reset: all outputs 0, pointers 0, count 0, pending 0, sticky 0. Reset mid-operation discards all FIFO contents and pending flags on the next edge.
- Latency: a request pushed at edge k is visible on the Q501H outputs after edge k (next cycle) if the FIFO was empty. Otherwise it appears after the preceding entries pop.
- Throughput: one push and one pop per cycle.
- The head entry and valid hold stable while C2F_RspStall = 1.
- C2F_ReqFullQ500H reflects registered count. It deasserts the cycle after a pop from full.
- Pending set is visible the cycle after the push. Clear is visible the cycle after the response.

## Structure
- lotr_pkg: reuse t_opcode (RD/WR). Add C2F_BUF_DEPTH = 4 as the default constant.
- One sub-module, c2f_fifo: parameterised storage array, read/write pointers, count, full/empty.
- The top level holds push/pop qualification, pending flags, and sticky errors.

## Test plan
- Single RD, thread 2, address 32'h0200_0010, empty FIFO, stall 0:
  - valid and address appear one cycle later, for one cycle;
  - ThreadRdPending = 4'b0100 until a Q502H response with thread 2, then 4'b0000.
- Four WRs, data 1..4, with stall held 1:
  - full asserts after the 4th, count = 4;
  - a 5th push is dropped and ErrSticky = 2'b01;
  - release stall: data 1,2,3,4 exit in order on consecutive cycles.
- Simultaneous push and pop at count 2 for 10 cycles: count stays 2, no data loss, order preserved across pointer wrap.
- Response for thread 1 with no pending read: ErrSticky[1] = 1, ThreadRdPending unchanged.
- Thread 0 RD response and a new thread 0 RD push in the same cycle: ThreadRdPending[0] remains 1.
- Reset asserted with 3 entries and 2 pending threads: next cycle valid = 0, count = 0, pending = 0, ErrSticky = 0.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared types for the core-to-fabric path: request opcode, buffered request
// record and the default request buffer depth.
// Purely declarative: no logic, no latency, no flow control.
package lotr_pkg;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } t_opcode;

    localparam int C2F_BUF_DEPTH = 4;

    // One buffered C2F request as it travels from Q500H to Q501H.
    typedef struct packed {
        t_opcode     opcode;
        logic [1:0]  thread;
        logic [31:0] addr;
        logic [31:0] data;
    } t_c2f_req;

    // Thread number to per-thread bit mask.
    function automatic logic [3:0] thread_onehot(input logic [1:0] thr);
        thread_onehot = 4'b0001 << thr;
    endfunction

endpackage

// File: rtl/c2f_req_buf_if.sv
// Bundles the core request port, ring request/response port and debug status.
// Wires only; latency and stall handling live in c2f_req_buf.
// slave = buffer view, master = core/ring/debug driver view.
interface c2f_req_buf_if
    import lotr_pkg::*;
#(
    parameter int DEPTH = C2F_BUF_DEPTH
);
    // Core side (Q500H)
    logic                     C2F_ReqValidQ500H;
    t_opcode                  C2F_ReqOpcodeQ500H;
    logic [1:0]               C2F_ReqThreadIDQ500H;
    logic [31:0]              C2F_ReqAddressQ500H;
    logic [31:0]              C2F_ReqDataQ500H;
    logic                     C2F_ReqFullQ500H;
    // Ring side (Q501H request, Q502H response)
    logic                     C2F_RingReqValidQ501H;
    t_opcode                  C2F_RingReqOpcodeQ501H;
    logic [1:0]               C2F_RingReqThreadIDQ501H;
    logic [31:0]              C2F_RingReqAddressQ501H;
    logic [31:0]              C2F_RingReqDataQ501H;
    logic                     C2F_RspStall;
    logic                     C2F_RspValidQ502H;
    logic [1:0]               C2F_RspThreadIDQ502H;
    // Status / debug
    logic [3:0]               ThreadRdPending;
    logic [$clog2(DEPTH):0]   C2F_BufCount;
    logic [1:0]               C2F_ErrSticky;

    modport slave (
        input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
               C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
               C2F_RspStall, C2F_RspValidQ502H, C2F_RspThreadIDQ502H,
        output C2F_ReqFullQ500H,
               C2F_RingReqValidQ501H, C2F_RingReqOpcodeQ501H, C2F_RingReqThreadIDQ501H,
               C2F_RingReqAddressQ501H, C2F_RingReqDataQ501H,
               ThreadRdPending, C2F_BufCount, C2F_ErrSticky
    );

    modport master (
        output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
               C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
               C2F_RspStall, C2F_RspValidQ502H, C2F_RspThreadIDQ502H,
        input  C2F_ReqFullQ500H,
               C2F_RingReqValidQ501H, C2F_RingReqOpcodeQ501H, C2F_RingReqThreadIDQ501H,
               C2F_RingReqAddressQ501H, C2F_RingReqDataQ501H,
               ThreadRdPending, C2F_BufCount, C2F_ErrSticky
    );

endinterface

// File: rtl/c2f_fifo.sv
// In-order request storage with read/write pointers and occupancy count.
// Latency: write at edge k is readable at o_head after edge k; head is combinational from storage.
// Backpressure: caller must not push when o_full nor pop when o_empty; full/empty come from the registered count.
// Ports: i_clk, i_rst (sync, high), i_push/i_wdat, i_pop, o_head, o_count, o_full, o_empty.
module c2f_fifo
    import lotr_pkg::*;
#(
    parameter int DEPTH = C2F_BUF_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  t_c2f_req               i_wdat,
    input  logic                   i_pop,
    output t_c2f_req               o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    t_c2f_req          r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/c2f_req_buf.sv
// Core-to-fabric request buffer: Q500H requests queued in order toward the ring, per-thread read tracking, sticky errors.
// Latency: push at edge k shows on Q501H after edge k when empty; pending set/clear visible one cycle after the event.
// Backpressure: C2F_RspStall holds the head; C2F_ReqFullQ500H (registered count) tells the core to stop; pushes while full are dropped.
// Ports: QClk, RstQnnnH (sync, high), bus (c2f_req_buf_if.slave: core request, ring request/response, status).
module c2f_req_buf
    import lotr_pkg::*;
#(
    parameter int DEPTH = C2F_BUF_DEPTH
) (
    input  logic            QClk,
    input  logic            RstQnnnH,
    c2f_req_buf_if.slave    bus
);
    t_c2f_req               w_wdat;
    t_c2f_req               w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic [3:0]             w_pend_set;
    logic [3:0]             w_pend_clr;
    logic                   w_rsp_orphan;

    logic [3:0]             r_pending;
    logic [1:0]             r_err;

    // A push while full is dropped even if a pop frees a slot this cycle,
    // because full is decoded from the registered count.
    assign w_push = bus.C2F_ReqValidQ500H && !w_full;
    assign w_drop = bus.C2F_ReqValidQ500H &&  w_full;
    assign w_pop  = !w_empty && !bus.C2F_RspStall;

    assign w_wdat = '{opcode: bus.C2F_ReqOpcodeQ500H,
                      thread: bus.C2F_ReqThreadIDQ500H,
                      addr:   bus.C2F_ReqAddressQ500H,
                      data:   bus.C2F_ReqDataQ500H};

    c2f_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (QClk),
        .i_rst   (RstQnnnH),
        .i_push  (w_push),
        .i_wdat  (w_wdat),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pending flags: set wins over clear so a fresh read is never lost.
    always_comb begin
        w_pend_set   = '0;
        w_pend_clr   = '0;
        w_rsp_orphan = 1'b0;
        if (w_push && (bus.C2F_ReqOpcodeQ500H == OP_RD)) begin
            w_pend_set = thread_onehot(bus.C2F_ReqThreadIDQ500H);
        end
        if (bus.C2F_RspValidQ502H) begin
            w_pend_clr   = thread_onehot(bus.C2F_RspThreadIDQ502H);
            w_rsp_orphan = !r_pending[bus.C2F_RspThreadIDQ502H];
        end
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            r_pending <= '0;
            r_err     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
            if (w_drop)       r_err[0] <= 1'b1;
            if (w_rsp_orphan) r_err[1] <= 1'b1;
        end
    end

    // Head fields are forced to zero when empty so stale storage never leaks.
    assign bus.C2F_ReqFullQ500H         = w_full;
    assign bus.C2F_RingReqValidQ501H    = !w_empty;
    assign bus.C2F_RingReqOpcodeQ501H   = w_empty ? OP_RD : w_head.opcode;
    assign bus.C2F_RingReqThreadIDQ501H = w_empty ? 2'd0  : w_head.thread;
    assign bus.C2F_RingReqAddressQ501H  = w_empty ? 32'd0 : w_head.addr;
    assign bus.C2F_RingReqDataQ501H     = w_empty ? 32'd0 : w_head.data;
    assign bus.ThreadRdPending          = r_pending;
    assign bus.C2F_BufCount             = w_count;
    assign bus.C2F_ErrSticky            = r_err;

endmodule
